// File: rtl/probe_launch_gen.sv
// Probe launch pattern generator: synchronises an external trigger and, per accepted
// edge, emits a one-cycle strobe and updates a 4-bit launch pattern held for HOLD_CYCLES.
module probe_launch_gen #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        system_clk,
  input  logic        S_AXI_aresetn,
  input  logic        trigger_in,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [3:0]  mask,
  input  logic        clear_count,
  output logic [3:0]  data_out,
  output logic        launch_strobe,
  output logic [15:0] launch_count,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    LAUNCH = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic s0_r;
  (* ASYNC_REG = "TRUE" *) logic s1_r;
  logic        s2_r;
  logic [2:0]  warm_r;
  logic        trig_edge_s;
  state_t      state_r;
  logic [7:0]  hold_cnt_r;
  logic [15:0] lfsr_r;
  logic [3:0]  data_r;
  logic        strobe_r;
  logic        busy_r;
  logic [15:0] count_r;
  logic        overrun_r;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10 when shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [3:0] pattern_next(input logic [1:0] m, input logic [3:0] msk,
                                              input logic [3:0] d, input logic [3:0] rnd);
    logic [3:0] r;
    case (m)
      2'b00:   r = d ^ msk;
      2'b01:   r = (rnd & msk) | (d & ~msk);
      2'b10:   r = (d == 4'b0000) ? 4'b0001 : {d[2:0], d[3]};
      2'b11:   r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  // warm_r masks the pipeline fill after reset so a trigger already high is not an edge.
  assign trig_edge_s = s1_r & ~s2_r & warm_r[2];

  // Trigger synchroniser and edge pipeline.
  always_ff @(posedge system_clk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      s0_r   <= 1'b0;
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      warm_r <= 3'b000;
    end else begin
      s0_r   <= trigger_in;
      s1_r   <= s0_r;
      s2_r   <= s1_r;
      warm_r <= {warm_r[1:0], 1'b1};
    end
  end

  // Launch FSM with registered strobe, busy, pattern and LFSR.
  always_ff @(posedge system_clk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      lfsr_r     <= LFSR_SEED;
      data_r     <= 4'b0000;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= enable ? ARM : IDLE;
        end
        ARM: begin
          if (!enable) begin
            state_r <= IDLE;
          end else if (trig_edge_s) begin
            state_r  <= LAUNCH;
            strobe_r <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r <= ARM;
          end
        end
        LAUNCH: begin
          state_r    <= HOLD;
          strobe_r   <= 1'b0;
          hold_cnt_r <= HOLD_LOAD;
          data_r     <= pattern_next(mode, mask, data_r, lfsr_r[3:0]);
          lfsr_r     <= lfsr_next(lfsr_r);
        end
        HOLD: begin
          if (hold_cnt_r == 8'd0) begin
            state_r <= enable ? ARM : IDLE;
            busy_r  <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          strobe_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Statistics: clear wins over a coincident increment or overrun set.
  always_ff @(posedge system_clk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      count_r   <= 16'd0;
      overrun_r <= 1'b0;
    end else if (clear_count) begin
      count_r   <= 16'd0;
      overrun_r <= 1'b0;
    end else begin
      if ((state_r == LAUNCH) && (count_r != 16'hFFFF)) begin
        count_r <= count_r + 16'd1;
      end
      if (trig_edge_s && ((state_r == LAUNCH) || (state_r == HOLD))) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign data_out      = data_r;
  assign launch_strobe = strobe_r;
  assign launch_count  = count_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;

endmodule

// File: doc/probe_launch_gen.md
PROBE_LAUNCH_GEN -- requirements
Module: probe_launch_gen

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: number of system_clk cycles spent in HOLD after each launch; legal range 1..255.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be non-zero.
REQ-003 Clock and reset: S_AXI_aresetn is asynchronous, active-low; the clock is system_clk.
REQ-004 Port system_clk, input, 1: all logic clocked on its rising edge.
REQ-005 Port S_AXI_aresetn, input, 1: asynchronous active-low reset.
REQ-006 Port trigger_in, input, 1: launch request, asynchronous to system_clk (driven from the shifting_clk domain of the probe detector).
REQ-007 Port enable, input, 1: run enable, quasi-static.
REQ-008 Port mode, input, 2: pattern mode, quasi-static.
REQ-009 Port mask, input, 4: per-bit pattern mask, quasi-static.
REQ-010 Port clear_count, input, 1: synchronous single-cycle clear of statistics.
REQ-011 Port data_out, output, 4: launch pattern feeding the probe detector data path.
REQ-012 Port launch_strobe, output, 1: high for exactly one cycle per launch.
REQ-013 Port launch_count, output, 16: number of launches, saturating.
REQ-014 Port busy, output, 1: high while in LAUNCH or HOLD.
REQ-015 Port overrun, output, 1: sticky flag for a dropped trigger.

Function
REQ-016 trigger_in shall pass through a two-flop synchronizer (s0, s1) marked ASYNC_REG; a registered copy s2 of s1 is kept, and edge = s1 & ~s2.
REQ-017 FSM states IDLE, ARM, LAUNCH, HOLD: IDLE->ARM when enable=1; ARM->IDLE when enable=0; otherwise ARM->LAUNCH when edge=1; LAUNCH->HOLD unconditionally; HOLD->ARM (enable=1) or HOLD->IDLE (enable=0) when hold_cnt=0.
REQ-018 On LAUNCH->HOLD, hold_cnt shall load HOLD_CYCLES-1; in HOLD it shall decrement by 1 per cycle, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-019 launch_strobe shall be a Moore output, high only in LAUNCH.
REQ-020 busy shall be high only in LAUNCH or HOLD.
REQ-021 Latency: if the first clock edge sampling trigger_in high is edge 1 and the FSM is in ARM, the FSM shall enter LAUNCH at edge 3 and data_out shall take its new value at edge 4.
REQ-022 mode and mask shall be used only at the LAUNCH cycle edge; data_out shall not change at any other time.
REQ-023 Mode 00 (toggle): data_out <= data_out XOR mask.
REQ-024 Mode 01 (random): data_out <= (lfsr[3:0] & mask) | (data_out & ~mask).
REQ-025 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
REQ-026 The LFSR shall advance once per LAUNCH in every mode; the mode 01 update shall use the pre-advance value.
REQ-027 Mode 10 (walk): data_out <= 4'b0001 if data_out==0, else data_out rotated left by 1; mask is ignored.
REQ-028 Mode 11 (hold): data_out is unchanged, but launch_strobe, launch_count and the LFSR behave normally.
REQ-029 launch_count shall increment by 1 at each LAUNCH cycle edge and saturate at 16'hFFFF (no wrap).
REQ-030 overrun shall set when edge=1 while the state is LAUNCH or HOLD; that edge is dropped and never queued.
REQ-031 Edges arriving in IDLE are ignored and shall not set overrun.
REQ-032 clear_count=1 shall zero launch_count and overrun at the next edge, with priority over a simultaneous increment or set (result 0); clear_count has no effect on the FSM or data_out.
REQ-033 Deasserting enable in LAUNCH or HOLD shall not truncate the launch or the hold period.

Reset
REQ-034 Reset assertion shall asynchronously force: state IDLE, data_out 4'b0000, launch_strobe 0, busy 0, launch_count 0, overrun 0, hold_cnt 0, lfsr LFSR_SEED, s0/s1/s2 0.
REQ-035 Reset asserted mid-HOLD or mid-LAUNCH shall abort the operation with no partial update.
REQ-036 After release, the block shall resume from IDLE, and a trigger_in already high shall not produce an edge.

Verification
REQ-037 Toggle: enable=1, mode=00, mask=4'b0101, trigger_in rises once -> data_out 0000->0101 at edge 4, one strobe, launch_count=1, busy high for 1+4 cycles.
REQ-038 Walk: mode=10, 5 triggers spaced 10 cycles apart -> data_out sequence 0001,0010,0100,1000,0001, launch_count=5, overrun=0.
REQ-039 Overrun: second trigger rising 2 cycles after the first (inside HOLD, HOLD_CYCLES=4) -> overrun=1, launch_count=1; then clear_count -> launch_count=0, overrun=0.
REQ-040 Random: mode=01, mask=4'b1111, from reset -> first data_out equals LFSR_SEED[3:0]=4'b0001; mask=0 -> data_out stays unchanged.
REQ-041 Saturation and clear priority: preload launch_count to 16'hFFFE, give 3 triggers -> count stays 16'hFFFF; clear_count coincident with a LAUNCH -> count 0.
REQ-042 Reset during HOLD, and enable=0 during HOLD: reset -> all REQ-034 values immediately; enable=0 -> hold completes, then IDLE, and later triggers are ignored.
